// File: rtl/imem_boot_loader_if.sv
// Loader stream and instruction-memory write bundle; slave is the loader, master is its driver.
interface imem_boot_loader_if;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [6:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, error
    );

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader into a 128x16 IMEM; holds CPU reset until the checksum matches.
// One word per 3 cycles best case; byte_ready is low in WRITE and outside accepting states.
module imem_boot_loader (
    input  logic              i_clk,
    input  logic              i_reset,
    imem_boot_loader_if.slave io_bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CHK, S_RUN, S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_count;
    logic [7:0]  r_acc;
    logic [7:0]  r_hi;
    logic [6:0]  r_index;
    logic [6:0]  r_waddr;
    logic [15:0] r_wdata;
    logic        r_byte_ready;
    logic        r_imem_we;
    logic        r_cpu_reset;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        w_xfer;
    logic        w_len_bad;
    logic        w_last;

    assign w_xfer    = io_bus.byte_valid & r_byte_ready;
    assign w_len_bad = (io_bus.byte_in == 8'd0) || (io_bus.byte_in > 8'd128);
    assign w_last    = ({1'b0, r_index} == (r_count - 8'd1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (io_bus.start) w_next = S_LEN;
            S_LEN:        if (w_xfer) w_next = w_len_bad ? S_ERR : S_HI;
            S_HI:         if (w_xfer) w_next = S_LO;
            S_LO:         if (w_xfer) w_next = S_WRITE;
            S_WRITE:      w_next = w_last ? S_CHK : S_HI;
            S_CHK:        if (w_xfer) w_next = (io_bus.byte_in == r_acc) ? S_RUN : S_ERR;
            S_RUN, S_ERR: if (io_bus.start) w_next = S_LEN;
            default:      w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_count      <= 8'd0;
            r_acc        <= 8'd0;
            r_hi         <= 8'd0;
            r_index      <= 7'd0;
            r_waddr      <= 7'd0;
            r_wdata      <= 16'd0;
            r_byte_ready <= 1'b0;
            r_imem_we    <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= w_next inside {S_LEN, S_HI, S_LO, S_CHK};
            r_busy       <= w_next inside {S_LEN, S_HI, S_LO, S_WRITE, S_CHK};
            r_imem_we    <= (w_next == S_WRITE);
            r_cpu_reset  <= (w_next != S_RUN);
            r_done       <= (w_next == S_RUN);
            r_error      <= (w_next == S_ERR);
            case (r_state)
                S_LEN: if (w_xfer) begin
                    r_count <= io_bus.byte_in;
                    r_index <= 7'd0;
                    r_acc   <= io_bus.byte_in;
                end
                S_HI: if (w_xfer) begin
                    r_hi  <= io_bus.byte_in;
                    r_acc <= r_acc ^ io_bus.byte_in;
                end
                // Address and data change only on entry to WRITE so they hold between strobes.
                S_LO: if (w_xfer) begin
                    r_wdata <= {r_hi, io_bus.byte_in};
                    r_waddr <= r_index;
                    r_acc   <= r_acc ^ io_bus.byte_in;
                end
                S_WRITE: if (!w_last) r_index <= r_index + 7'd1;
                default: ;
            endcase
        end
    end

    assign io_bus.byte_ready = r_byte_ready;
    assign io_bus.imem_we    = r_imem_we;
    assign io_bus.imem_waddr = r_waddr;
    assign io_bus.imem_wdata = r_wdata;
    assign io_bus.cpu_reset  = r_cpu_reset;
    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
    assign io_bus.error      = r_error;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frame table plus hand-written corner sequences.
module tb_imem_boot_loader;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_boot_loader_if bus();
    imem_boot_loader dut (.i_clk(clk), .i_reset(rst), .io_bus(bus));

    typedef struct packed {
        logic [63:0] bytes;   // byte k of the frame in bits [8k+7:8k]
        int          nb;
        logic [47:0] words;   // word k expected at address k in bits [16k+15:16k]
        int          nw;
        logic        exp_done;
        int          cycles;  // LEN entry to RUN/ERR with no stalls
    } vec_t;

    vec_t        vecs[7];
    logic [7:0]  frame_q[$];
    logic [6:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    logic [15:0] rnd_words[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            chk("ready_in_write", 32'(bus.byte_ready), 32'd0);
            wr_addr.push_back(bus.imem_waddr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic r;
        int   guard;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        r     = 1'b0;
        guard = 0;
        while (!r && guard < 64) begin
            @(negedge clk);
            r = bus.byte_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!r) chk("byte_accept_timeout", 32'(r), 32'd1);
    endtask

    task automatic send_frame(input bit gaps, input bit poke_start, output int elapsed);
        int t0;
        int guard;
        int g;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = poke_start;
        t0 = cyc;
        chk("len_ready", 32'(bus.byte_ready), 32'd1);
        chk("len_flags", 32'({bus.done, bus.error, bus.cpu_reset, bus.busy}), 32'b0011);
        foreach (frame_q[i]) begin
            if (gaps) begin
                g = $urandom_range(3, 0);
                bus.byte_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(frame_q[i]);
        end
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        guard = 0;
        while (!(bus.done || bus.error) && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard == 1000) chk("finish_timeout", 32'(bus.done | bus.error), 32'd1);
        elapsed = cyc - t0;
    endtask

    task automatic check_end(input string tag, input logic exp_done);
        chk({tag, "_done"},  32'(bus.done),      32'(exp_done));
        chk({tag, "_error"}, 32'(bus.error),     32'(!exp_done));
        chk({tag, "_cpurst"},32'(bus.cpu_reset), 32'(!exp_done));
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] x = 8'd0;
        foreach (frame_q[i]) x ^= frame_q[i];
        return x;
    endfunction

    initial begin
        int         el;
        vec_t       v;
        logic [7:0] b;
        // good checksum is 02^F0^01^5F^FF = 53; A1 is a deliberate mismatch
        vecs[0] = '{64'h0000_53FF_5F01_F002, 6, 48'h0000_5FFF_F001, 2, 1'b1, 8};
        vecs[1] = '{64'h0000_A1FF_5F01_F002, 6, 48'h0000_5FFF_F001, 2, 1'b0, 8};
        vecs[2] = '{64'h0000_0000_0000_0000, 1, 48'h0, 0, 1'b0, 1};
        vecs[3] = '{64'h0000_0000_0000_0081, 1, 48'h0, 0, 1'b0, 1};
        vecs[4] = '{64'h0000_0000_2734_1201, 4, 48'h0000_0000_1234, 1, 1'b1, 5};
        vecs[5] = '{64'h0303_0002_0001_0003, 8, 48'h0003_0002_0001, 3, 1'b1, 11};
        vecs[6] = '{64'h0000_0000_0000_00FF, 1, 48'h0, 0, 1'b0, 1};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.byte_in = 8'd0;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_outputs", 32'({bus.byte_ready, bus.imem_we, bus.cpu_reset, bus.busy, bus.done, bus.error}),
            32'b001000);
        chk("rst_waddr", 32'(bus.imem_waddr), 32'd0);
        chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);

        for (int k = 0; k < 7; k++) begin
            v = vecs[k];
            frame_q.delete();
            wr_addr.delete();
            wr_data.delete();
            for (int i = 0; i < v.nb; i++) frame_q.push_back(v.bytes[i*8 +: 8]);
            send_frame(1'b0, 1'b0, el);
            check_end($sformatf("vec%0d", k), v.exp_done);
            chk($sformatf("vec%0d_cycles", k), 32'(el), 32'(v.cycles));
            chk($sformatf("vec%0d_nwrites", k), 32'(wr_addr.size()), 32'(v.nw));
            for (int i = 0; i < v.nw && i < wr_addr.size(); i++) begin
                chk($sformatf("vec%0d_addr%0d", k, i), 32'(wr_addr[i]), 32'(i));
                chk($sformatf("vec%0d_data%0d", k, i), 32'(wr_data[i]), 32'(v.words[i*16 +: 16]));
            end
        end

        // Full 128-word image, no stalls.
        frame_q.delete();
        wr_addr.delete();
        wr_data.delete();
        rnd_words.delete();
        frame_q.push_back(8'h80);
        for (int i = 0; i < 128; i++) begin
            rnd_words.push_back(16'($urandom));
            frame_q.push_back(rnd_words[i][15:8]);
            frame_q.push_back(rnd_words[i][7:0]);
        end
        b = xsum();
        frame_q.push_back(b);
        send_frame(1'b0, 1'b0, el);
        check_end("n128", 1'b1);
        chk("n128_cycles", 32'(el), 32'd386);
        chk("n128_nwrites", 32'(wr_addr.size()), 32'd128);
        for (int i = 0; i < 128 && i < wr_addr.size(); i++) begin
            chk($sformatf("n128_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            chk($sformatf("n128_data%0d", i), 32'(wr_data[i]), 32'(rnd_words[i]));
        end

        // N=3 frame with random valid gaps must write the same words.
        v = vecs[5];
        frame_q.delete();
        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < v.nb; i++) frame_q.push_back(v.bytes[i*8 +: 8]);
        send_frame(1'b1, 1'b0, el);
        check_end("gaps", 1'b1);
        chk("gaps_nwrites", 32'(wr_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            chk($sformatf("gaps_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            chk($sformatf("gaps_data%0d", i), 32'(wr_data[i]), 32'(v.words[i*16 +: 16]));
        end

        // Reset in the middle of word 1 of an N=4 load.
        wr_addr.delete();
        wr_data.delete();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_outputs", 32'({bus.byte_ready, bus.imem_we, bus.cpu_reset, bus.busy, bus.done, bus.error}),
            32'b001000);
        chk("midrst_waddr", 32'(bus.imem_waddr), 32'd0);
        chk("midrst_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_idle_hold", 32'({bus.busy, bus.byte_ready}), 32'd0);

        frame_q.delete();
        wr_addr.delete();
        wr_data.delete();
        frame_q = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        b = xsum();
        frame_q.push_back(b);
        send_frame(1'b0, 1'b1, el);
        check_end("reload", 1'b1);
        chk("reload_cycles", 32'(el), 32'd14);
        chk("reload_nwrites", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            chk($sformatf("reload_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            chk($sformatf("reload_data%0d", i), 32'(wr_data[i]),
                32'({frame_q[1 + 2*i], frame_q[2 + 2*i]}));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("run_sticky", 32'({bus.done, bus.cpu_reset, bus.busy}), 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
